// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory access controller for the 5-stage RISC-V pipeline.
// A load or store in EX/MEM becomes a single word-addressed req/ack
// transaction with byte enables. The pipeline is stalled until memory
// answers, or until the watchdog expires. The formatted load value is then
// held on ReadData_o for MEM/WB.
//
// Parameters
//   TIMEOUT      cycles to wait for mem_ack_i before faulting (0 = no watchdog)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   MemRead_i    EX/MEM instruction is a load
//   MemWrite_i   EX/MEM instruction is a store (wins over MemRead_i)
//   funct3_i     access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   Addr_i       byte address
//   WriteData_i  store data
//   ReadData_o   formatted load result (held until the next load completes)
//   Stall_o      freezes PC, IF/ID, ID/EX, EX/MEM
//   Fault_o      one-cycle pulse: misaligned, illegal funct3 or timeout
//   mem_req_o    memory request
//   mem_we_o     1 = write
//   mem_addr_o   word address
//   mem_be_o     byte enables (4'b1111 for reads)
//   mem_wdata_o  lane-replicated store data
//   mem_ack_i    memory completion, read data valid in the same cycle
//   mem_rdata_i  read word
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        Fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // The counter only has to reach TIMEOUT-1 before the watchdog fires.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Formatting and legality helpers
  // ---------------------------------------------------------------------------
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b10:   ok = (off == 2'b00);
      2'b01:   ok = ~off[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store data into every lane so the byte enables alone pick
  // the bytes that memory writes.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic        [7:0]  b_u;
    logic        [15:0] h_u;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r;
    b_u = word[{off, 3'b000} +: 8];
    h_u = off[1] ? word[31:16] : word[15:0];
    b_s = signed'(b_u);
    h_s = signed'(h_u);
    case (f3)
      3'b000:  r = 32'(b_s);
      3'b001:  r = 32'(h_s);
      3'b100:  r = signed'({24'd0, b_u});
      3'b101:  r = signed'({16'd0, h_u});
      default: r = signed'(word);
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode (combinational, seen in IDLE)
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic [31:0]      read_data_q;

  logic             access;
  logic             legal;
  logic             start;
  logic             stall;
  logic             fault;
  logic             busy;
  logic             tmo_hit;

  // Transaction captured on entry to BUSY; gated onto the bus only while BUSY.
  logic [31:0]      addr_p1;
  logic [3:0]       be_p1;
  logic [31:0]      wdata_p1;
  logic             we_p1;
  logic [2:0]       f3_p1;
  logic [1:0]       off_p1;

  assign access  = MemRead_i | MemWrite_i;
  assign legal   = f3_legal(funct3_i) && is_aligned(funct3_i[1:0], Addr_i[1:0]);
  assign busy    = (state_q == BUSY);
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    fault   = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            stall   = 1'b1;
            start   = 1'b1;
            state_d = BUSY;
          end else begin
            fault   = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack_i || tmo_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Inputs still show the completing instruction; do not decode them.
        fault   = tmo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the combinational outputs low even though EX/MEM may still
  // present a memory instruction while rst_i is asserted.
  assign Stall_o = rst_i & stall;
  assign Fault_o = rst_i & fault;

  // ---------------------------------------------------------------------------
  // Stage p1: transaction capture (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (start) begin
      addr_p1  <= {Addr_i[31:2], 2'b00};
      off_p1   <= Addr_i[1:0];
      f3_p1    <= funct3_i;
      we_p1    <= MemWrite_i;
      be_p1    <= MemWrite_i ? store_be(funct3_i[1:0], Addr_i[1:0]) : 4'b1111;
      wdata_p1 <= MemWrite_i ? store_wdata(funct3_i[1:0], WriteData_i) : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, watchdog and load result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
        tmo_q <= 1'b0;
      end
      if (busy) begin
        if (mem_ack_i) begin
          if (!we_p1) begin
            read_data_q <= load_fmt(f3_p1, off_p1, mem_rdata_i);
          end
        end else if (tmo_hit) begin
          tmo_q <= 1'b1;
          if (!we_p1) begin
            read_data_q <= 32'd0;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory bus: driven from the captured transaction only while BUSY, so the
  // request drops asynchronously with reset and reads zero otherwise.
  // ---------------------------------------------------------------------------
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_p1;
  assign mem_addr_o  = busy ? addr_p1  : 32'd0;
  assign mem_be_o    = busy ? be_p1    : 4'd0;
  assign mem_wdata_o = busy ? wdata_p1 : 32'd0;
  assign ReadData_o  = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        Stall_o;
  logic        Fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent access
  int          stall_n;
  int          req_n;
  logic        done_seen;
  logic        end_fault;
  logic [31:0] end_rd;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .funct3_i    (funct3_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .ReadData_o  (ReadData_o),
    .Stall_o     (Stall_o),
    .Fault_o     (Fault_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one access at a falling edge, answer the request after 'waits'
  // request cycles, and stop in the first cycle with Stall_o low (DONE, or the
  // IDLE cycle itself for a rejected access).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits);
    @(negedge clk_i);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    funct3_i    = f3;
    Addr_i      = addr;
    WriteData_i = wdata;
    mem_rdata_i = rdata;
    mem_ack_i   = 1'b0;
    stall_n     = 0;
    req_n       = 0;
    done_seen   = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      #1;
      if (mem_req_o) begin
        req_n++;
        if (req_n == 1) begin
          seen_addr  = mem_addr_o;
          seen_wdata = mem_wdata_o;
          seen_be    = mem_be_o;
          seen_we    = mem_we_o;
        end
        mem_ack_i = (req_n > waits);
      end else begin
        mem_ack_i = 1'b0;
      end
      if (Stall_o) begin
        stall_n++;
      end else begin
        done_seen = 1'b1;
        end_fault = Fault_o;
        end_rd    = ReadData_o;
      end
      if (!done_seen) @(negedge clk_i);
    end
    mem_ack_i = 1'b0;
    chk("access_finished", {31'd0, done_seen}, 32'd1);
  endtask

  task automatic release_inputs();
    @(negedge clk_i);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    funct3_i    = 3'b000;
    Addr_i      = 32'd0;
    WriteData_i = 32'd0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_readdata", ReadData_o, 32'd0);
    chk("rst_stall", {31'd0, Stall_o}, 32'd0);
    chk("rst_fault", {31'd0, Fault_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("idle_req", {31'd0, mem_req_o}, 32'd0);
    chk("idle_stall", {31'd0, Stall_o}, 32'd0);

    // lw zero-wait
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    chk("lw_stall_cycles", stall_n, 2);
    chk("lw_req_cycles", req_n, 1);
    chk("lw_addr", seen_addr, 32'h100);
    chk("lw_be", {28'd0, seen_be}, 32'hF);
    chk("lw_we", {31'd0, seen_we}, 32'd0);
    chk("lw_rdata", end_rd, 32'hDEADBEEF);
    chk("lw_fault", {31'd0, end_fault}, 32'd0);
    release_inputs();
    chk("lw_after_req", {31'd0, mem_req_o}, 32'd0);
    chk("lw_after_addr", mem_addr_o, 32'd0);

    // lb / lbu lane 3, two wait cycles
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 2);
    chk("lb_stall_cycles", stall_n, 4);
    chk("lb_addr", seen_addr, 32'h100);
    chk("lb_rdata", end_rd, 32'hFFFF_FF80);
    release_inputs();
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 2);
    chk("lbu_stall_cycles", stall_n, 4);
    chk("lbu_rdata", end_rd, 32'h0000_0080);
    release_inputs();

    // lh upper half, lhu lower half, one wait cycle
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF_0000, 1);
    chk("lh_stall_cycles", stall_n, 3);
    chk("lh_rdata", end_rd, 32'hFFFF_80FF);
    release_inputs();
    access(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 32'h1234_8765, 0);
    chk("lhu_rdata", end_rd, 32'h0000_8765);
    release_inputs();

    // sh at 0x0A
    access(1'b0, 1'b1, 3'b001, 32'h0A, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
    chk("sh_be", {28'd0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, seen_we}, 32'd1);
    chk("sh_addr", seen_addr, 32'h08);
    chk("sh_readdata_kept", end_rd, 32'h0000_8765);
    release_inputs();

    // sb lane 1
    access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'd0, 0);
    chk("sb_be", {28'd0, seen_be}, 32'h2);
    chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    release_inputs();

    // sw with MemRead also high: store wins
    access(1'b1, 1'b1, 3'b010, 32'h200, 32'h1122_3344, 32'hFFFF_FFFF, 0);
    chk("sw_be", {28'd0, seen_be}, 32'hF);
    chk("sw_wdata", seen_wdata, 32'h1122_3344);
    chk("sw_we", {31'd0, seen_we}, 32'd1);
    chk("sw_readdata_kept", end_rd, 32'h0000_8765);
    release_inputs();

    // Misaligned lw
    access(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0);
    chk("mis_lw_stall", stall_n, 0);
    chk("mis_lw_req", req_n, 0);
    chk("mis_lw_fault", {31'd0, end_fault}, 32'd1);
    chk("mis_lw_readdata", end_rd, 32'h0000_8765);
    release_inputs();
    chk("mis_lw_fault_pulse_end", {31'd0, Fault_o}, 32'd0);

    // Illegal funct3 011
    access(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0);
    chk("f3_011_req", req_n, 0);
    chk("f3_011_stall", stall_n, 0);
    chk("f3_011_fault", {31'd0, end_fault}, 32'd1);
    release_inputs();
    chk("f3_011_fault_pulse_end", {31'd0, Fault_o}, 32'd0);

    // Misaligned sh is suppressed
    access(1'b0, 1'b1, 3'b001, 32'h0B, 32'h5555_5555, 32'd0, 0);
    chk("mis_sh_req", req_n, 0);
    chk("mis_sh_fault", {31'd0, end_fault}, 32'd1);
    release_inputs();

    // Timeout: ack never comes
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'hFFFF_FFFF, 100);
    chk("tmo_req_cycles", req_n, 4);
    chk("tmo_stall_cycles", stall_n, 5);
    chk("tmo_fault", {31'd0, end_fault}, 32'd1);
    chk("tmo_readdata", end_rd, 32'd0);
    release_inputs();
    chk("tmo_fault_pulse_end", {31'd0, Fault_o}, 32'd0);

    // Load something nonzero so the reset clear is visible
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'h0BAD_F00D, 0);
    chk("pre_rst_rdata", end_rd, 32'h0BAD_F00D);
    release_inputs();

    // Reset while BUSY; load stays presented during reset
    @(negedge clk_i);
    MemRead_i = 1'b1;
    funct3_i  = 3'b010;
    Addr_i    = 32'h104;
    mem_ack_i = 1'b0;
    #1;
    chk("mid_idle_stall", {31'd0, Stall_o}, 32'd1);
    @(negedge clk_i);
    #1;
    chk("mid_busy_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, Stall_o}, 32'd0);
    chk("mid_rst_fault", {31'd0, Fault_o}, 32'd0);
    chk("mid_rst_readdata", ReadData_o, 32'd0);
    @(negedge clk_i);
    MemRead_i = 1'b0;
    rst_i     = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'hCAFE_F00D, 1);
    chk("post_rst_stall_cycles", stall_n, 3);
    chk("post_rst_addr", seen_addr, 32'h104);
    chk("post_rst_rdata", end_rd, 32'hCAFE_F00D);
    chk("post_rst_fault", {31'd0, end_fault}, 32'd0);
    release_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller for the MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register. It converts load/store requests into a word-addressed req/ack transaction with byte enables, and stalls the pipeline until the memory responds. It then delivers the sign/zero-extended load value to MEM/WB `ReadData_i`.

## Interface
Parameters:
- `TIMEOUT`, default 1023: the maximum number of cycles to wait for `mem_ack_i`. A value of 0 disables the watchdog.

Ports:
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: asynchronous reset, active-low.
- `MemRead_i` input 1: the instruction in EX/MEM is a load.
- `MemWrite_i` input 1: the instruction in EX/MEM is a store. It wins if both read and write are high.
- `funct3_i` input 3: access size and sign. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `Addr_i` input 32: byte address (the ALU result).
- `WriteData_i` input 32: store data (rs2).
- `ReadData_o` output 32: formatted load result. It feeds MEM/WB `ReadData_i`.
- `Stall_o` output 1: freezes PC, IF/ID, ID/EX and EX/MEM. The top level gates MEM/WB `RegWrite_i`/`MemtoReg_i` with `~Stall_o`.
- `Fault_o` output 1: a one-cycle pulse for a misaligned access, an illegal funct3, or a timeout.
- `mem_req_o` output 1: memory request.
- `mem_we_o` output 1: 1 = write.
- `mem_addr_o` output 32: word address `{Addr[31:2],2'b00}`.
- `mem_be_o` output 4: byte enables. 4'b1111 for reads.
- `mem_wdata_o` output 32: lane-replicated store data.
- `mem_ack_i` input 1: memory completion. Read data is valid in the same cycle.
- `mem_rdata_i` input 32: read word.

## Operation
The state machine has three states: IDLE, BUSY and DONE. Reset state is IDLE.

**IDLE**
- An access is either `MemRead_i` or `MemWrite_i`.
- Legal access:
  - `Stall_o`=1 combinationally.
  - Capture address, data, byte enables, funct3 and we.
  - Clear the timeout counter.
  - Next state is BUSY.
- Illegal access: misaligned (w with `Addr[1:0]`≠0, h/hu with `Addr[0]`≠0) or funct3 ∈ {011, 110, 111}:
  - No request is issued.
  - `Stall_o`=0 and `Fault_o`=1 in this cycle.
  - A store is suppressed, and `ReadData_o` is unchanged.
  - Stay in IDLE.

**BUSY**
- `mem_req_o`=1, `Stall_o`=1.
- All `mem_*` outputs are held stable from the captured values.
- When `mem_ack_i`=1:
  - A load registers the formatted `mem_rdata_i` into `ReadData_o`.
  - Next state is DONE.
- Otherwise the counter increments.
- If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no ack:
  - Drop the request.
  - A load sets `ReadData_o`=0.
  - Set the fault flag and go to DONE.

**DONE**
- `Stall_o`=0, so the instruction advances into MEM/WB on this edge.
- `Fault_o`=1 only if the access timed out.
- The inputs are ignored, because they still show the completing instruction.
- Next state is IDLE.

`mem_ack_i` is ignored outside BUSY.

**Load formatting**
- Byte lane is `Addr[1:0]`.
- lb sign-extends bit 7 of the lane; lbu zero-extends.
- Half lane is `Addr[1]`; lh sign-extends and lhu zero-extends.
- lw passes the word through.

**Store formatting**
- sb: be = 4'b0001<<`Addr[1:0]`, wdata = {4{WriteData[7:0]}}.
- sh: be = 4'b0011<<(2·`Addr[1]`), wdata = {2{WriteData[15:0]}}.
- sw: be = 4'b1111, wdata = WriteData.

`ReadData_o` holds its value until the next load completes. Stores never change it.

## Timing
**Reset values:** `ReadData_o`=0, `Stall_o`=0, `Fault_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_be_o`=0, `mem_wdata_o`=0, state IDLE, counter 0.

**Latency:** an access is seen in IDLE at cycle T and `mem_req_o` rises at T+1.
- Zero-wait ack at T+1 gives DONE at T+2. The access occupies MEM for 3 cycles, with `Stall_o` high at T and T+1.
- Each wait cycle adds 1 cycle.

**Handshake:** `mem_req_o` stays high until the cycle in which `mem_ack_i` is sampled high, inclusive, or until timeout. It drops on the next edge.

**Back-to-back accesses:** a new access presented in the cycle after DONE starts normally. There is no dead cycle beyond DONE.

**Reset during BUSY:** `mem_req_o` drops immediately, asynchronously. The memory must abort, and no fault is reported.

**Non-memory instructions:** in IDLE with neither read nor write asserted, all outputs except `ReadData_o` are 0.

## Test plan
- **lw, zero-wait:** Addr=0x100, `mem_rdata_i`=0xDEADBEEF, ack at the first req cycle → `Stall_o` high 2 cycles; `ReadData_o`=0xDEADBEEF in DONE; `mem_be_o`=4'hF; `mem_addr_o`=0x100.
- **lb/lbu, lane 3:** Addr=0x103, rdata=0x80FF_0000, 2 wait cycles → lb gives 0xFFFF_FF80; lbu gives 0x0000_0080; `Stall_o` high 4 cycles.
- **sh at Addr=0x0A:** WriteData=0x1234ABCD → `mem_be_o`=4'b1100, `mem_wdata_o`=0xABCDABCD, `mem_we_o`=1; `ReadData_o` unchanged.
- **Misaligned lw:** Addr=0x102, then funct3=011 → no `mem_req_o`, `Stall_o`=0, `Fault_o` one-cycle pulse each time.
- **Timeout:** `TIMEOUT`=4, ack never asserted → `mem_req_o` high exactly 4 cycles; then DONE with `Fault_o`=1 and `ReadData_o`=0.
- **Reset mid-BUSY:** deassert `rst_i` while waiting → `mem_req_o` and `Stall_o` go 0 asynchronously; after release, a new lw completes normally.
